// File: rtl/split_constraint_pipe.sv
// Two-stage pipelined split constraint evaluator with a valid/ready stream,
// saturating pass/fail counters and capture of the first passing candidate.
module split_constraint_pipe #(
  parameter int A_W   = 13,
  parameter int B_W   = 7,
  parameter int SHIFT = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic [1:0]       in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_x,
  output logic [1:0]       out_flags,
  input  logic             clr,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_vld,
  output logic [A_W-1:0]   first_a,
  output logic [B_W-1:0]   first_b
);

  logic           s1_valid;
  logic [A_W-1:0] s1_a;
  logic [B_W-1:0] s1_b;
  logic [1:0]     s1_mask;
  logic [A_W-1:0] s2_a;
  logic [B_W-1:0] s2_b;

  logic           adv2;
  logic           in_fire;
  logic           out_fire;
  logic [A_W-1:0] n;
  logic [A_W-1:0] n_shl;
  logic [A_W-1:0] n_diff;
  logic           shift_nz;
  logic           diff_nz;
  logic           x_next;

  assign adv2     = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | adv2;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Constraint evaluation on the S1 candidate, all arithmetic modulo 2^A_W.
  always_comb begin
    n        = ~s1_a;
    n_shl    = n << SHIFT;
    n_diff   = n - A_W'(s1_b);
    shift_nz = |n_shl;
    diff_nz  = |n_diff;
    x_next   = (~s1_mask[0] | shift_nz) & (~s1_mask[1] | diff_nz);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mask  <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_mask  <= in_mask;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 only moves when the verdict slot is free or being consumed, so the
  // outputs hold steady under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_x     <= 1'b0;
      out_flags <= '0;
      s2_a      <= '0;
      s2_b      <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_x     <= x_next;
        out_flags <= {diff_nz, shift_nz};
        s2_a      <= s1_a;
        s2_b      <= s1_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      first_vld <= 1'b0;
      first_a   <= '0;
      first_b   <= '0;
    end else if (clr) begin
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      first_vld <= 1'b0;
    end else if (out_fire) begin
      if (out_x) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
        if (!first_vld) begin
          first_vld <= 1'b1;
          first_a   <= s2_a;
          first_b   <= s2_b;
        end
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_split_constraint_pipe.sv
// Directed self-checking bench for split_constraint_pipe (CNT_W = 4 so the
// counter saturation case is reachable in a short run).
module tb_split_constraint_pipe;

  localparam int A_W   = 13;
  localparam int B_W   = 7;
  localparam int SHIFT = 1;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic [1:0]       in_mask;
  logic             out_valid;
  logic             out_ready;
  logic             out_x;
  logic [1:0]       out_flags;
  logic             clr;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             first_vld;
  logic [A_W-1:0]   first_a;
  logic [B_W-1:0]   first_b;

  int checks = 0;
  int errors = 0;

  split_constraint_pipe #(
    .A_W(A_W), .B_W(B_W), .SHIFT(SHIFT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_flags(out_flags),
    .clr(clr),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_vld(first_vld), .first_a(first_a), .first_b(first_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push one candidate, then leave it waiting in S2 with out_valid high.
  task automatic applyStimulus(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input logic [1:0] m);
    in_a = a; in_b = b; in_mask = m; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic checkVerdict(input string tag, input logic x, input logic [1:0] flags);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_x"}, 32'(out_x), 32'(x));
    checkOutput({tag, "_flags"}, 32'(out_flags), 32'(flags));
  endtask

  logic [A_W-1:0] bp_a [4];
  logic [B_W-1:0] bp_b [4];
  logic [2:0]     bp_exp [4];
  logic [2:0]     seen [$];

  initial begin
    int idx;
    int acc_at_stall;
    int stale;
    logic acc;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mask = 2'b11;
    out_ready = 1'b1; clr = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_x_flags", 32'({out_x, out_flags}), 32'd0);
    checkOutput("rst_cnts", 32'({pass_cnt, fail_cnt}), 32'd0);
    checkOutput("rst_first", 32'({first_vld, first_a, first_b}), 32'd0);

    // n = 0: both constraints fail
    applyStimulus(13'h1FFF, 7'h00, 2'b11);
    checkVerdict("all_ones", 1'b0, 2'b00);
    step();
    checkOutput("all_ones_fail_cnt", 32'(fail_cnt), 32'd1);
    checkOutput("all_ones_drained", 32'(out_valid), 32'd0);

    applyStimulus(13'h1000, 7'h7F, 2'b11);
    checkVerdict("pass1", 1'b1, 2'b11);
    step();
    checkOutput("pass1_pass_cnt", 32'(pass_cnt), 32'd1);
    checkOutput("pass1_first_vld", 32'(first_vld), 32'd1);
    checkOutput("pass1_first_a", 32'(first_a), 32'h1000);
    checkOutput("pass1_first_b", 32'(first_b), 32'h7F);

    // shift result truncates away
    applyStimulus(13'h0FFF, 7'h03, 2'b11);
    checkVerdict("trunc_m11", 1'b0, 2'b10);
    step();
    applyStimulus(13'h0FFF, 7'h03, 2'b10);
    checkVerdict("trunc_m10", 1'b1, 2'b10);
    step();
    applyStimulus(13'h0FFF, 7'h03, 2'b00);
    checkVerdict("trunc_m00", 1'b1, 2'b10);
    step();
    checkOutput("trunc_first_a_kept", 32'(first_a), 32'h1000);

    applyStimulus(13'h1FFA, 7'h05, 2'b11);
    checkVerdict("diff0_m11", 1'b0, 2'b01);
    step();
    applyStimulus(13'h1FFA, 7'h05, 2'b01);
    checkVerdict("diff0_m01", 1'b1, 2'b01);
    step();
    checkOutput("dir_pass_cnt", 32'(pass_cnt), 32'd4);
    checkOutput("dir_fail_cnt", 32'(fail_cnt), 32'd3);

    // Back-pressure: four candidates, out_ready low for the first four cycles
    bp_a[0] = 13'h1000; bp_b[0] = 7'h7F; bp_exp[0] = 3'b111;
    bp_a[1] = 13'h1FFF; bp_b[1] = 7'h00; bp_exp[1] = 3'b000;
    bp_a[2] = 13'h0FFF; bp_b[2] = 7'h03; bp_exp[2] = 3'b010;
    bp_a[3] = 13'h1000; bp_b[3] = 7'h00; bp_exp[3] = 3'b111;
    idx = 0; acc_at_stall = -1; in_mask = 2'b11;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid  = (idx < 4);
      in_a      = bp_a[idx < 4 ? idx : 3];
      in_b      = bp_b[idx < 4 ? idx : 3];
      out_ready = (cyc >= 4);
      #4;
      if (cyc == 2) begin
        acc_at_stall = idx;
        checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      if (cyc == 2 || cyc == 3)
        checkOutput("bp_stall_hold", 32'({out_valid, out_x, out_flags}), 32'b1111);
      acc = in_valid & in_ready;
      if (out_valid && out_ready) seen.push_back({out_x, out_flags});
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    checkOutput("bp_accepted_before_stall", 32'(acc_at_stall), 32'd2);
    checkOutput("bp_emit_count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < seen.size())
        checkOutput($sformatf("bp_order%0d", i), 32'(seen[i]), 32'(bp_exp[i]));
    checkOutput("bp_pass_cnt", 32'(pass_cnt), 32'd6);
    checkOutput("bp_fail_cnt", 32'(fail_cnt), 32'd5);

    // Saturation: 20 more passes on top of 6
    in_a = 13'h1000; in_b = 7'h00; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) checkOutput("sat_full_rate", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    checkOutput("sat_pass_cnt", 32'(pass_cnt), 32'd15);
    checkOutput("sat_fail_cnt", 32'(fail_cnt), 32'd5);

    // clr coincident with an output handshake
    applyStimulus(13'h1000, 7'h00, 2'b11);
    checkVerdict("clr_cand", 1'b1, 2'b11);
    clr = 1'b1;
    step();
    clr = 1'b0;
    checkOutput("clr_pass_cnt", 32'(pass_cnt), 32'd0);
    checkOutput("clr_fail_cnt", 32'(fail_cnt), 32'd0);
    checkOutput("clr_first_vld", 32'(first_vld), 32'd0);
    checkOutput("clr_first_a_kept", 32'(first_a), 32'h1000);

    applyStimulus(13'h0000, 7'h01, 2'b11);
    checkVerdict("recap", 1'b1, 2'b11);
    step();
    checkOutput("recap_first", 32'({first_vld, first_a, first_b}), 32'({1'b1, 13'h0000, 7'h01}));
    checkOutput("recap_pass_cnt", 32'(pass_cnt), 32'd1);

    // Reset with two candidates in flight
    out_ready = 1'b0; in_valid = 1'b1; in_a = 13'h1000; in_b = 7'h7F;
    step(); step();
    in_valid = 1'b0;
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 32'(out_valid), 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) stale++;
    end
    checkOutput("rst_no_stale", 32'(stale), 32'd0);
    checkOutput("rst_cnts_after", 32'({pass_cnt, fail_cnt, first_vld}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
